adc_scan_scheduler: RTL
=======================

// Module: adc_scan_scheduler
// PURPOSE
//  Sequences the ADC128S022 serial frame engine. Runs periodic scans over a channel mask
//  and accepts single on-demand conversions from a requester. Handles the ADC's one-frame
//  address pipeline: data returned in frame k belongs to the address sent in frame k-1.
//  Writes tagged 12-bit results to the per-channel result registers downstream.
// PARAMETERS
//  PERIOD_CYC   2500  clk_50 cycles between scan ticks (50 us at 50 MHz)
//  TIMEOUT_CYC  1024  max cycles from fe_start to fe_done before abort
// PORTS
//  clk_50       in   1   system clock, 50 MHz
//  rst_n        in   1   asynchronous active-low reset
//  enable       in   1   scheduler enable
//  ch_mask      in   8   channels in a scan; bit i = channel i
//  od_valid     in   1   on-demand request valid
//  od_ch        in   3   on-demand channel
//  od_ready     out  1   on-demand accepted when od_valid & od_ready
//  fe_start     out  1   1-cycle pulse; starts one 16-SCK frame
//  fe_addr      out  3   channel address for the frame; held from fe_start to fe_done
//  fe_busy      in   1   frame engine busy
//  fe_done      in   1   1-cycle pulse; frame complete, fe_data valid this cycle
//  fe_data      in   12  conversion data of the previously addressed channel
//  res_valid    out  1   1-cycle result write strobe
//  res_ch       out  3   channel of res_data
//  res_data     out  12  conversion result
//  res_od       out  1   result is from an on-demand request
//  scan_done    out  1   1-cycle pulse after the last write of a scan
//  timeout_err  out  1   sticky frame timeout flag
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; counters and pending flags cleared; fe_start never asserted.
//  Tick counter: free-runs only while enable=1. Tick every PERIOD_CYC cycles. Reset to 0 when enable=0.
//  FSM states: IDLE, ISSUE, WAIT_DONE, WRITE.
//  IDLE: od_ready = enable & ~fe_busy.
//   - Priority: od handshake > pending tick.
//   - Tick arriving in the same cycle as an od accept sets tick_pend. The scan runs after the od completes.
//   - Ticks arriving while not in IDLE set tick_pend. Only one is held; extra ticks are dropped.
//  Scan start: latch ch_mask. If it is 0, clear tick_pend, issue nothing and do not pulse scan_done.
//   - Otherwise build the ascending list L[0..N-1] of set bits. Issue N+1 frames.
//   - Frame k addresses L[k] for k<N. The final frame k=N addresses L[0].
//   - The result of frame 0 is discarded. The result of frame k>=1 is written with res_ch = L[k-1].
//   - ch_mask changes mid-scan are ignored.
//  On-demand: issue 2 frames, both addressed od_ch. Discard the first result.
//   - Write the second with res_od=1. No scan_done pulse.
//  ISSUE: fe_start=1 for one cycle, only when fe_busy=0; otherwise wait in ISSUE. Go to WAIT_DONE.
//  WAIT_DONE: on fe_done capture fe_data.
//   - res_valid/res_ch/res_data/res_od are registered and asserted the cycle after fe_done (latency 1).
//   - Then ISSUE the next frame, or go to IDLE.
//   - scan_done pulses in the same cycle as the last res_valid of a scan.
//  Timeout: a counter starts at fe_start. If no fe_done arrives within TIMEOUT_CYC cycles:
//   - set timeout_err, abort to IDLE, clear tick_pend;
//   - no res_valid and no scan_done for that scan.
//  fe_done outside WAIT_DONE: ignored.
//  enable 1->0 mid-operation: finish the in-flight frame (fe_done or timeout), drop its result, go IDLE.
//   - tick_pend is cleared. timeout_err clears while enable=0.
//  rst_n low mid-frame: immediate return to reset state; the frame engine is reset by the same rst_n.
// TESTING
//  1. mask=8'hE0; model returns 12'h500+prev_addr; one tick.
//     -> fe_addr 5,6,7,5; writes ch5=505, ch6=506, ch7=507; one scan_done.
//  2. IDLE, od_valid=1, od_ch=3.
//     -> od_ready handshake 1 cycle; two frames addr 3; one write ch3, res_od=1; no scan_done.
//  3. Tick and od accept in the same cycle, mask=8'h01.
//     -> od frames (addr 2,2) first, then scan frames addr 0,0; writes in that order.
//  4. Model withholds fe_done.
//     -> timeout_err=1 exactly TIMEOUT_CYC cycles after fe_start; FSM IDLE; no res_valid.
//     -> Toggle enable low clears timeout_err.
//  5. rst_n low during scan frame 2.
//     -> all outputs 0 asynchronously. After release, the next tick restarts the scan at lowest channel.
//  6. mask=0 at tick -> no fe_start, no scan_done.
//     mask 8'h03->8'hFF mid-scan -> scan completes on ch0, ch1 only.

Source files
------------

// File: rtl/adc_scan_scheduler.sv
// adc_scan_scheduler
//   Sequences the ADC128S022 frame engine: periodic scans over a channel mask
//   plus single on-demand conversions. The ADC returns, in frame k, the data of
//   the channel addressed in frame k-1, so every transaction issues one extra
//   frame and discards the first result.
// Ports
//   clk_50, rst_n             clock, asynchronous active-low reset
//   enable, ch_mask           scheduler enable, scan channel mask (bit i = ch i)
//   od_valid/od_ch/od_ready   on-demand request handshake
//   fe_start/fe_addr          frame start pulse and frame address (held)
//   fe_busy/fe_done/fe_data   frame engine status and returned data
//   res_valid/res_ch/res_data/res_od   result write strobe and payload
//   scan_done                 pulse with the last write of a scan
//   timeout_err               sticky frame timeout flag (clears while enable=0)
module adc_scan_scheduler #(
  parameter int unsigned PERIOD_CYC  = 2500,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk_50,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [7:0]  ch_mask,
  input  logic        od_valid,
  input  logic [2:0]  od_ch,
  output logic        od_ready,
  output logic        fe_start,
  output logic [2:0]  fe_addr,
  input  logic        fe_busy,
  input  logic        fe_done,
  input  logic [11:0] fe_data,
  output logic        res_valid,
  output logic [2:0]  res_ch,
  output logic [11:0] res_data,
  output logic        res_od,
  output logic        scan_done,
  output logic        timeout_err
);

  localparam int unsigned TICK_W = $clog2(PERIOD_CYC + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    WRITE     = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                tick_pend_q, tick_pend_d;
  logic [7:0]          rem_q, rem_d;          // scan channels not yet addressed
  logic [2:0]          first_addr_q, first_addr_d;
  logic [2:0]          prev_q, prev_d;        // address of the previous frame
  logic                is_od_q, is_od_d;
  logic                first_q, first_d;      // current frame's result is discarded
  logic                last_q, last_d;        // current frame closes the transaction
  logic                armed_q;               // keeps od_ready low while in reset

  logic                fe_start_d;
  logic [2:0]          fe_addr_d;
  logic                res_valid_d;
  logic [2:0]          res_ch_d;
  logic [11:0]         res_data_d;
  logic                res_od_d;
  logic                scan_done_d;
  logic                timeout_err_d;
  logic                tick;

  // Lowest set bit of a channel mask (0 when empty).
  function automatic logic [2:0] low_bit(input logic [7:0] m);
    low_bit = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) low_bit = 3'(i);
    end
  endfunction

  assign tick     = enable & (tick_cnt_q == TICK_W'(PERIOD_CYC - 1));
  assign od_ready = armed_q & (state_q == IDLE) & enable & ~fe_busy;

  // State and datapath registers.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      tmo_q        <= '0;
      tick_pend_q  <= 1'b0;
      rem_q        <= '0;
      first_addr_q <= '0;
      prev_q       <= '0;
      is_od_q      <= 1'b0;
      first_q      <= 1'b0;
      last_q       <= 1'b0;
      armed_q      <= 1'b0;
      fe_start     <= 1'b0;
      fe_addr      <= '0;
      res_valid    <= 1'b0;
      res_ch       <= '0;
      res_data     <= '0;
      res_od       <= 1'b0;
      scan_done    <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      tmo_q        <= tmo_d;
      tick_pend_q  <= tick_pend_d;
      rem_q        <= rem_d;
      first_addr_q <= first_addr_d;
      prev_q       <= prev_d;
      is_od_q      <= is_od_d;
      first_q      <= first_d;
      last_q       <= last_d;
      armed_q      <= 1'b1;
      fe_start     <= fe_start_d;
      fe_addr      <= fe_addr_d;
      res_valid    <= res_valid_d;
      res_ch       <= res_ch_d;
      res_data     <= res_data_d;
      res_od       <= res_od_d;
      scan_done    <= scan_done_d;
      timeout_err  <= timeout_err_d;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d       = state_q;
    tmo_d         = tmo_q;
    tick_pend_d   = tick_pend_q;
    rem_d         = rem_q;
    first_addr_d  = first_addr_q;
    prev_d        = prev_q;
    is_od_d       = is_od_q;
    first_d       = first_q;
    last_d        = last_q;
    fe_start_d    = 1'b0;
    fe_addr_d     = fe_addr;
    res_valid_d   = 1'b0;
    res_ch_d      = res_ch;
    res_data_d    = res_data;
    res_od_d      = res_od;
    scan_done_d   = 1'b0;
    timeout_err_d = timeout_err & enable;
    tick_cnt_d    = enable ? (tick ? '0 : tick_cnt_q + TICK_W'(1)) : '0;

    // Hold at most one tick; the IDLE branch consumes it.
    if (tick)    tick_pend_d = 1'b1;
    if (!enable) tick_pend_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (od_valid & od_ready) begin
          is_od_d   = 1'b1;
          first_d   = 1'b1;
          last_d    = 1'b0;
          fe_addr_d = od_ch;
          state_d   = ISSUE;
        end else if (enable & (tick | tick_pend_q)) begin
          tick_pend_d = 1'b0;
          if (ch_mask != 8'd0) begin
            is_od_d      = 1'b0;
            first_d      = 1'b1;
            last_d       = 1'b0;
            fe_addr_d    = low_bit(ch_mask);
            first_addr_d = low_bit(ch_mask);
            rem_d        = ch_mask & (ch_mask - 8'd1);
            state_d      = ISSUE;
          end
        end
      end

      ISSUE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (!fe_busy) begin
          fe_start_d = 1'b1;
          tmo_d      = '0;
          state_d    = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        if (fe_done) begin
          if (!enable) begin
            state_d = IDLE;
          end else begin
            state_d = WRITE;
            if (!first_q) begin
              res_valid_d = 1'b1;
              res_ch_d    = prev_q;
              res_data_d  = fe_data;
              res_od_d    = is_od_q;
              scan_done_d = last_q & ~is_od_q;
            end
          end
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          state_d       = IDLE;
          tick_pend_d   = 1'b0;
          timeout_err_d = enable;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      WRITE: begin
        if (last_q | !enable) begin
          state_d = IDLE;
        end else begin
          prev_d  = fe_addr;
          first_d = 1'b0;
          state_d = ISSUE;
          if (is_od_q) begin
            last_d = 1'b1;
          end else if (rem_q != 8'd0) begin
            fe_addr_d = low_bit(rem_q);
            rem_d     = rem_q & (rem_q - 8'd1);
          end else begin
            // Extra frame re-addresses the first channel to flush the pipeline.
            fe_addr_d = first_addr_q;
            last_d    = 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
